uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//   Parametrised UART receiver and successor to the fixed 8N1 receiver. Runtime-fixed frame format:
//   configurable data bits, optional odd/even parity and 1 or 2 stop bits.
//   Adds an RX synchroniser, false-start rejection, framing/parity/overrun flags
//   and a first-word-fall-through (FWFT) receive FIFO.
//   Sits between the RX pin and the host/command-processing logic.
// PARAMETERS
//   CLK_DIV    2604  clocks per bit (50MHz/19200); >=8, CLK_DIV/2 used for mid-bit
//   DATA_BITS  8     data bits per frame, 5..9, LSB first
//   PARITY     0     0 none, 1 odd, 2 even
//   STOP_BITS  1     1 or 2
//   FIFO_DEPTH 4     receive FIFO entries, power of 2, >=2
// PORTS
//   clk          in   1          system clock
//   rst_n        in   1          async active-low reset
//   RX           in   1          serial input, async to clk, idle high
//   rd_en        in   1          pop head of FIFO; ignored when empty
//   err_clr      in   1          clears all sticky error flags
//   rx_data      out  DATA_BITS  FIFO head (valid while rx_rdy=1)
//   rx_rdy       out  1          FIFO not empty
//   fifo_full    out  1          FIFO holds FIFO_DEPTH entries
//   parity_err   out  1          sticky: a frame had bad parity
//   frame_err    out  1          sticky: a stop bit sampled 0
//   overrun      out  1          sticky: frame arrived with FIFO full
// BEHAVIOUR
//   Reset: all outputs 0, FIFO empty, FSM IDLE, sync flops preset to 1.
//   Sync: RX passes through 2 flops (rx_s); falling edge = rx_s 0 with previous 1.
//   baud_cnt counts down; a sample is taken when it reaches 0, then it reloads CLK_DIV-1.
//   FSM states:
//   - IDLE: on falling edge -> START; load baud_cnt = CLK_DIV/2-1.
//   - START: at sample, rx_s=1 -> IDLE (glitch rejected, no flags); else -> DATA.
//   - DATA: DATA_BITS samples shifted in LSB first -> PARITY if PARITY!=0, else STOP.
//   - PARITY: one sample, checked against the data; odd=1 means the count of ones
//     including the parity bit must be odd -> STOP.
//   - STOP: STOP_BITS samples, any 0 = framing error; after last sample -> IDLE.
//     A held-low (break) line never retriggers, because IDLE needs a new falling edge.
//   Frame commit happens at the clk edge of the last stop sample:
//   - frame_err: frame discarded, frame_err set.
//   - else if FIFO full: frame discarded, overrun set.
//   - else: frame pushed; parity_err set if parity bad (frame still pushed).
//   Latency: rx_rdy rises the cycle after commit; the last stop sample is
//   mid-bit + 2 sync cycles after the true line time.
//   FIFO: FWFT, rx_data = head. Pop on rd_en&rx_rdy. Push and pop in the same cycle
//     are both honoured, including when full (no overrun then) and when empty with a
//     push (pop ignored as empty, push lands).
//   Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full/empty come from the MSB compare.
//   Sticky flags: err_clr clears; a new error in the same cycle as err_clr wins (flag stays 1).
//   rd_en/err_clr have no effect on the FSM; back-to-back frames need no idle gap beyond the stop bit(s).
//   Async reset mid-frame: FSM->IDLE, partial frame lost, FIFO emptied, flags cleared.
//   Unused rx_data upper bits: none; width is exactly DATA_BITS.
// TESTING (bench CLK_DIV=16 unless noted)
//   1. 8N1, send 0xA5 -> rx_rdy=1 after ~9.5 bit times, rx_data=0xA5, no flags; rd_en -> rx_rdy=0.
//   2. RX low pulse of 4 clks -> no frame, no flags, FSM back in IDLE.
//   3. PARITY=2, send 0x03 with parity bit 1 -> frame pushed, parity_err=1; err_clr -> 0.
//   4. Stop bit 0 on 0x55 -> no push, frame_err=1; line held low 40 bit times -> no further frames.
//   5. FIFO_DEPTH=4, send 5 frames, no reads -> fifo_full=1, overrun=1, 4 heads read back in order.
//   6. Push coincident with rd_en while full -> no overrun, count stays 4; reset mid-DATA -> all clear.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : Parametrised UART receiver (data bits, parity, stop bits) with
//             RX synchroniser, sticky error flags and a FWFT receive FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_DIV    = 2604,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 fifo_full,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int c_CW = $clog2(CLK_DIV);
    localparam int c_BW = $clog2(DATA_BITS + 1);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_HALF      = c_CW'(CLK_DIV / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL      = c_CW'(CLK_DIV - 1);
    localparam logic [c_BW-1:0] c_LAST_DATA = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_LAST_STOP = c_BW'(STOP_BITS - 1);
    localparam logic            c_ODD       = (PARITY == 1);
    localparam logic            c_HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_rx_meta, r_rx_s, r_rx_prev;
    logic [c_CW-1:0]       r_baud_cnt;
    logic [c_BW-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bad, r_frame_bad;
    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [c_AW:0]         r_wr_ptr, r_rd_ptr;
    logic                  r_parity_err, r_frame_err, r_overrun;

    logic w_fall, w_sample, w_commit, w_stop_bad;
    logic w_empty, w_full, w_pop, w_good, w_push;

    // Sync flops preset high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_fall     = ~r_rx_s & r_rx_prev;
    assign w_sample   = (r_state != S_IDLE) && (r_baud_cnt == '0);
    assign w_stop_bad = r_frame_bad | ~r_rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE:   if (w_fall) w_state_nxt = S_START;
            S_START:  if (w_sample) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_sample && (r_bit_cnt == c_LAST_DATA))
                          w_state_nxt = c_HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (w_sample) w_state_nxt = S_STOP;
            S_STOP:   if (w_sample && (r_bit_cnt == c_LAST_STOP)) begin
                          w_state_nxt = S_IDLE;
                          w_commit    = 1'b1;
                      end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_bad   <= 1'b0;
            r_frame_bad <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_fall) r_baud_cnt <= c_HALF;
            end else if (w_sample) begin
                r_baud_cnt <= c_FULL;
            end else begin
                r_baud_cnt <= r_baud_cnt - 1'b1;
            end

            if (r_state != w_state_nxt) r_bit_cnt <= '0;
            else if (w_sample)          r_bit_cnt <= r_bit_cnt + 1'b1;

            if (r_state == S_START) begin
                r_par_bad   <= 1'b0;
                r_frame_bad <= 1'b0;
            end

            if (w_sample) begin
                case (r_state)
                    S_DATA:   r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                    S_PARITY: r_par_bad <= (^r_shift) ^ r_rx_s ^ c_ODD;
                    S_STOP:   if (!r_rx_s) r_frame_bad <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    // A pop in the commit cycle frees the slot, so a full FIFO can still accept
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = rd_en & ~w_empty;
    assign w_good  = w_commit & ~w_stop_bad;
    assign w_push  = w_good & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // New error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= (w_push & r_par_bad) | (r_parity_err & ~err_clr);
            r_frame_err  <= (w_commit & w_stop_bad) | (r_frame_err & ~err_clr);
            r_overrun    <= (w_good & w_full & ~w_pop) | (r_overrun & ~err_clr);
        end
    end

    assign rx_data    = r_mem[r_rd_ptr[c_AW-1:0]];
    assign rx_rdy     = ~w_empty;
    assign fifo_full  = w_full;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
